// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
// Shared definitions for the Gray-code counter slice:
//   - legal WIDTH range for the counter
//   - bin2gray / gray2bin conversion helpers, written at the maximum width
//     (32 bits). Callers zero-extend narrower values and truncate the result.
//     This works because a zero upper part converts to zero in both
//     directions and leaves the lower bits unaffected.
// ---------------------------------------------------------------------------
package gray_pkg;

    localparam int GRAY_WIDTH_MIN = 2;
    localparam int GRAY_WIDTH_MAX = 32;

    // Binary to reflected Gray code.
    function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(
        input logic [GRAY_WIDTH_MAX-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Reflected Gray code to binary. Each binary bit is the XOR of all
    // Gray bits at or above its position.
    function automatic logic [GRAY_WIDTH_MAX-1:0] gray2bin(
        input logic [GRAY_WIDTH_MAX-1:0] g
    );
        logic [GRAY_WIDTH_MAX-1:0] b;
        b = '0;
        for (int i = 0; i < GRAY_WIDTH_MAX; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage : gray_pkg

// File: rtl/gray_code_counter_gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter for the counter's load path.
// Ports:
//   gray_in  [WIDTH-1:0] : Gray-coded input
//   bin_out  [WIDTH-1:0] : binary equivalent
// b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]. This is equivalent to
// b[i] = XOR of g[MSB:i], so no bit depends on another output bit.
// ---------------------------------------------------------------------------
module gray2bin
    import gray_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] bin_out
);

    always_comb begin
        bin_out = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_out[i] = ^(gray_in >> i);
        end
    end

endmodule : gray2bin

// File: rtl/gray_code_counter.sv
// ---------------------------------------------------------------------------
// gray_code_counter
// Up/down binary counter with a parallel Gray-coded output and a synchronous
// Gray-coded load. Both representations are held in flops, so gray_out
// leaves the module straight from a register and cannot glitch.
//
// Parameters:
//   WIDTH   : counter width, 2..32
//   RST_BIN : binary value loaded by reset, must fit in WIDTH bits
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   en        : count enable
//   up_dn     : 1 = increment, 0 = decrement
//   load      : synchronous load strobe (takes priority over en)
//   load_gray : Gray-coded load value
//   bin_out   : registered binary count
//   gray_out  : registered Gray count, always bin2gray(bin_out)
//   wrap      : one-cycle pulse after a counting edge that wraps around
// ---------------------------------------------------------------------------
module gray_code_counter
    import gray_pkg::*;
#(
    parameter int          WIDTH   = 4,
    parameter int unsigned RST_BIN = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    // Elaboration-time parameter checks.
    if (WIDTH < GRAY_WIDTH_MIN || WIDTH > GRAY_WIDTH_MAX) begin : g_bad_width
        $error("gray_code_counter: WIDTH out of range 2..32");
    end
    if ((64'(RST_BIN) >> WIDTH) != 64'd0) begin : g_bad_rst
        $error("gray_code_counter: RST_BIN does not fit in WIDTH bits");
    end

    localparam logic [WIDTH-1:0] RST_BIN_V  = WIDTH'(RST_BIN);
    localparam logic [WIDTH-1:0] RST_GRAY_V = RST_BIN_V ^ (RST_BIN_V >> 1);
    localparam logic [WIDTH-1:0] ONE_V      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_V      = '1;

    // Narrow wrapper around the 32-bit package conversion.
    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return WIDTH'(bin2gray(32'(b)));
    endfunction

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] load_bin;

    gray2bin #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .gray_in (load_gray),
        .bin_out (load_bin)
    );

    // Next state: load > count > hold. wrap is only raised by counting
    // edges, so a load of 0 or all-ones never pulses it.
    always_comb begin
        bin_d  = bin_q;
        gray_d = gray_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d  = load_bin;
            gray_d = to_gray(load_bin);
        end else if (en) begin
            if (up_dn) begin
                bin_d  = bin_q + ONE_V;
                wrap_d = (bin_q == MAX_V);
            end else begin
                bin_d  = bin_q - ONE_V;
                wrap_d = (bin_q == '0);
            end
            gray_d = to_gray(bin_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= RST_BIN_V;
            gray_q <= RST_GRAY_V;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule : gray_code_counter

// File: tb/tb_gray_code_counter.sv
// ---------------------------------------------------------------------------
// tb_gray_code_counter
// Directed bench for gray_code_counter with WIDTH=4, RST_BIN=0.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// ---------------------------------------------------------------------------
module tb_gray_code_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_gray;
    logic [3:0] bin_out;
    logic [3:0] gray_out;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    logic [3:0] prev_gray;
    logic [3:0] exp_b;

    gray_code_counter #(
        .WIDTH   (4),
        .RST_BIN (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .load_gray (load_gray),
        .bin_out   (bin_out),
        .gray_out  (gray_out),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] b, input logic [3:0] g,
                           input logic w);
        chk({tag, ".bin"},  32'(bin_out),  32'(b));
        chk({tag, ".gray"}, 32'(gray_out), 32'(g));
        chk({tag, ".wrap"}, 32'(wrap),     32'(w));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        en        = 1'b0;
        up_dn     = 1'b1;
        load      = 1'b0;
        load_gray = 4'b0000;
        rst       = 1'b1;

        // Reset acts with no clock edge (first edge is at t=5).
        #2;
        chk_out("reset_async", 4'b0000, 4'b0000, 1'b0);
        #5;
        rst = 1'b0;
        chk_out("reset_release", 4'b0000, 4'b0000, 1'b0);

        // Count up 15 edges, then wrap on the 16th.
        en        = 1'b1;
        up_dn     = 1'b1;
        prev_gray = gray_out;
        for (int i = 1; i <= 15; i++) begin
            step();
            exp_b = 4'(i);
            chk("up.bin", 32'(bin_out), 32'(exp_b));
            chk("up.gray", 32'(gray_out), 32'(exp_b ^ (exp_b >> 1)));
            chk("up.wrap", 32'(wrap), 32'd0);
            chk("up.onebit", 32'($countones(prev_gray ^ gray_out)), 32'd1);
            prev_gray = gray_out;
        end
        chk_out("up_15", 4'b1111, 4'b1000, 1'b0);
        step();
        chk_out("up_wrap", 4'b0000, 4'b0000, 1'b1);
        chk("up_wrap.onebit", 32'($countones(prev_gray ^ gray_out)), 32'd1);

        // Hold one edge: wrap must drop.
        en = 1'b0;
        step();
        chk_out("wrap_drop", 4'b0000, 4'b0000, 1'b0);

        // Count down from zero.
        en    = 1'b1;
        up_dn = 1'b0;
        step();
        chk_out("down_wrap", 4'b1111, 4'b1000, 1'b1);
        step();
        chk_out("down_next", 4'b1110, 4'b1001, 1'b0);

        // Load beats enable.
        load      = 1'b1;
        load_gray = 4'b0110;
        en        = 1'b1;
        up_dn     = 1'b1;
        step();
        chk_out("load_prio", 4'b0100, 4'b0110, 1'b0);

        // Loads of all-ones and zero never pulse wrap.
        load_gray = 4'b1000;
        step();
        chk_out("load_max", 4'b1111, 4'b1000, 1'b0);
        load_gray = 4'b0000;
        step();
        chk_out("load_zero", 4'b0000, 4'b0000, 1'b0);

        // Load 0101 (Gray 0111), then hold for 3 edges.
        load_gray = 4'b0111;
        step();
        chk_out("load_5", 4'b0101, 4'b0111, 1'b0);
        load = 1'b0;
        en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            up_dn = ~up_dn;
            step();
            chk_out("hold", 4'b0101, 4'b0111, 1'b0);
        end

        // Direction flip on every edge, no dead cycle.
        en    = 1'b1;
        up_dn = 1'b1;
        step();
        chk_out("flip_up1", 4'b0110, 4'b0101, 1'b0);
        up_dn = 1'b0;
        step();
        chk_out("flip_down", 4'b0101, 4'b0111, 1'b0);
        up_dn = 1'b1;
        step();
        chk_out("flip_up2", 4'b0110, 4'b0101, 1'b0);

        // Reach 1010 (Gray 1111) and reset between edges.
        load      = 1'b1;
        load_gray = 4'b1111;
        step();
        chk_out("load_10", 4'b1010, 4'b1111, 1'b0);
        load  = 1'b0;
        en    = 1'b1;
        up_dn = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_out("rst_mid", 4'b0000, 4'b0000, 1'b0);
        rst = 1'b0;
        #0.5;
        chk_out("rst_mid_release", 4'b0000, 4'b0000, 1'b0);
        step();
        chk_out("after_rst", 4'b0001, 4'b0001, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_gray_code_counter

// File: doc/gray_code_counter.md
GRAY_CODE_COUNTER -- requirements
Module: gray_code_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter bit width; legal range 2..32.
REQ-002 SHALL have parameter RST_BIN, default 0, binary count value loaded on reset; must be less than 2^WIDTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port en, input, 1, count enable.
REQ-006 SHALL have port up_dn, input, 1, direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port load, input, 1, synchronous load strobe.
REQ-008 SHALL have port load_gray, input, WIDTH, load value, Gray-coded.
REQ-009 SHALL have port bin_out, output, WIDTH, registered binary count.
REQ-010 SHALL have port gray_out, output, WIDTH, registered Gray-coded count.
REQ-011 SHALL have port wrap, output, 1, registered one-cycle wrap pulse.

Function
REQ-012 SHALL drive gray_out directly from a flop, with no combinational logic between flop and port, so the output is glitch-free.
REQ-013 SHALL keep gray_out equal to bin_out ^ (bin_out >> 1) in every cycle, including after reset and after load.
REQ-014 SHALL apply priority load > en > hold in each cycle.
REQ-015 SHALL, when load=1, convert load_gray to binary (b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]), and SHALL make bin_out and gray_out reflect the loaded value on the next edge.
REQ-016 SHALL, when load=0 and en=1, step bin_out by +1 (up_dn=1) or -1 (up_dn=0) modulo 2^WIDTH, with gray_out updated on the same edge.
REQ-017 SHALL, when load=0 and en=0, hold all count state.
REQ-018 SHALL assert wrap for exactly one cycle after a counting edge that goes from 2^WIDTH-1 to 0 (up) or from 0 to 2^WIDTH-1 (down); otherwise wrap=0.
REQ-019 SHALL keep wrap=0 after any load edge, including a load of 0 or of 2^WIDTH-1.
REQ-020 SHALL change exactly one gray_out bit on every counting edge, including wrap-around edges.
REQ-021 SHALL apply a direction change on the first enabled edge that sees the new up_dn value, with no dead cycle.
REQ-022 SHALL have single-edge latency: inputs sampled at edge N are visible on the outputs after edge N.

Reset
REQ-023 SHALL, while rst=1, immediately force bin_out=RST_BIN, gray_out=RST_BIN ^ (RST_BIN >> 1) and wrap=0, independent of clk.
REQ-024 SHALL resume counting on the first rising clk edge after rst deasserts; an assertion mid-count discards the in-flight value.

Structure
REQ-025 SHALL hold the shared bin-to-Gray and Gray-to-bin conversion functions and the WIDTH limits in a shared package gray_pkg.
REQ-026 SHALL instantiate one combinational sub-module gray2bin (WIDTH-parameterised) for the load path; the next-state Gray value SHALL use the package function.

Verification (WIDTH=4, RST_BIN=0)
REQ-027 SHALL cover reset: rst=1 pulse -> bin_out=0000, gray_out=0000, wrap=0 without any clock edge.
REQ-028 SHALL cover count up: en=1, up_dn=1 for 15 edges -> bin_out=1111, gray_out=1000; on the 16th edge -> bin_out=0000, gray_out=0000, wrap=1 for one cycle; the bench checks one-bit Gray change on every edge.
REQ-029 SHALL cover count down from zero: from 0 with en=1, up_dn=0, one edge -> bin_out=1111, gray_out=1000, wrap=1; next edge -> bin_out=1110, gray_out=1001, wrap=0.
REQ-030 SHALL cover load priority: load=1, load_gray=0110, en=1 on the same edge -> bin_out=0100, gray_out=0110, wrap=0.
REQ-031 SHALL cover hold and direction flip: en=0 for 3 edges -> outputs unchanged; then up_dn toggled every edge from bin_out=0101 -> 0110, 0101, 0110.
REQ-032 SHALL cover reset mid-count: rst asserted between edges while bin_out=1010 -> outputs 0000 immediately; first edge after release with en=1, up_dn=1 -> bin_out=0001, gray_out=0001.
